// File: rtl/ysyx_20020207_clint_if.sv
// AR/R read channel bundle between the crossbar port and the CLINT.
// Master drives address and accept; slave returns data and response.
interface ysyx_20020207_clint_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic        high;
  logic        arready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rready;

  modport master (
    output arvalid, araddr, high, rready,
    input  arready, rvalid, rresp, rdata
  );

  modport slave (
    input  arvalid, araddr, high, rready,
    output arready, rvalid, rresp, rdata
  );
endinterface

// File: rtl/ysyx_20020207_clint.sv
// Read-only CLINT mtime responder: 64-bit prescaled counter, one word per read.
// Optional CLINT_SNAPSHOT_EN: low-word read latches the high half for coherent reads.
module ysyx_20020207_clint #(
  parameter int unsigned TICK_DIV   = 1,
  parameter logic [63:0] MTIME_INIT = 64'h0,
  parameter logic [31:0] ADDR_LO    = 32'h2000_bff8
) (
  input logic                  clock,
  input logic                  reset,
  ysyx_20020207_clint_if.slave bus
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic [DW-1:0] r_div;
  logic [63:0] r_mtime;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_tick;
  logic        w_ar_hs;
  logic        w_hit;
  logic [31:0] w_hi_word;
  logic [31:0] w_word;
  logic        w_unused;

  assign w_tick   = (r_div == DIV_MAX);
  assign w_ar_hs  = bus.arvalid && r_arready;
  assign w_hit    = (bus.araddr[31:3] == ADDR_LO[31:3]);
  assign w_word   = bus.high ? w_hi_word : r_mtime[31:0];
  assign w_unused = ^bus.araddr[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_mtime <= MTIME_INIT;
    end else if (w_tick) begin
      r_div   <= '0;
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_div   <= r_div + DW'(1);
    end
  end

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] r_snap;

  // Only successful low-word reads refresh the latched high half.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
    end else if (w_ar_hs && w_hit && !bus.high) begin
      r_snap <= r_mtime[63:32];
    end
  end

  assign w_hi_word = r_snap;
`else
  assign w_hi_word = r_mtime[63:32];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.arvalid) begin
            r_state   <= S_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= w_hit ? RESP_OKAY : RESP_DECERR;
            r_rdata   <= w_hit ? w_word : 32'h0;
          end
        end
        S_RESP: begin
          if (bus.rready) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rresp   = r_rresp;
  assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_ysyx_20020207_clint.sv
// Bench: four CLINT configurations share one stimulus stream and are
// checked every cycle against an arithmetic mtime/transaction model.
module tb_ysyx_20020207_clint;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = 32'h2000_bff8;
  logic        high = 1'b0;
  logic        rready = 1'b0;

  int vec = 0;
  int mis = 0;

  always #5 clock = ~clock;

  ysyx_20020207_clint_if if0 ();
  ysyx_20020207_clint_if if1 ();
  ysyx_20020207_clint_if if2 ();
  ysyx_20020207_clint_if if3 ();

  assign if0.arvalid = arvalid;
  assign if0.araddr  = araddr;
  assign if0.high    = high;
  assign if0.rready  = rready;
  assign if1.arvalid = arvalid;
  assign if1.araddr  = araddr;
  assign if1.high    = high;
  assign if1.rready  = rready;
  assign if2.arvalid = arvalid;
  assign if2.araddr  = araddr;
  assign if2.high    = high;
  assign if2.rready  = rready;
  assign if3.arvalid = arvalid;
  assign if3.araddr  = araddr;
  assign if3.high    = high;
  assign if3.rready  = rready;

  ysyx_20020207_clint #(
    .TICK_DIV(1), .MTIME_INIT(64'h0)
  ) u0 (.clock(clock), .reset(reset), .bus(if0.slave));

  ysyx_20020207_clint #(
    .TICK_DIV(4), .MTIME_INIT(64'h0)
  ) u1 (.clock(clock), .reset(reset), .bus(if1.slave));

  ysyx_20020207_clint #(
    .TICK_DIV(1), .MTIME_INIT(64'h0000_0000_FFFF_FFF0)
  ) u2 (.clock(clock), .reset(reset), .bus(if2.slave));

  ysyx_20020207_clint #(
    .TICK_DIV(1), .MTIME_INIT(64'hFFFF_FFFF_FFFF_FFFF)
  ) u3 (.clock(clock), .reset(reset), .bus(if3.slave));

  logic        o_arready [4];
  logic        o_rvalid  [4];
  logic [1:0]  o_rresp   [4];
  logic [31:0] o_rdata   [4];

  assign o_arready[0] = if0.arready;
  assign o_rvalid[0]  = if0.rvalid;
  assign o_rresp[0]   = if0.rresp;
  assign o_rdata[0]   = if0.rdata;
  assign o_arready[1] = if1.arready;
  assign o_rvalid[1]  = if1.rvalid;
  assign o_rresp[1]   = if1.rresp;
  assign o_rdata[1]   = if1.rdata;
  assign o_arready[2] = if2.arready;
  assign o_rvalid[2]  = if2.rvalid;
  assign o_rresp[2]   = if2.rresp;
  assign o_rdata[2]   = if2.rdata;
  assign o_arready[3] = if3.arready;
  assign o_rvalid[3]  = if3.rvalid;
  assign o_rresp[3]   = if3.rresp;
  assign o_rdata[3]   = if3.rdata;

  function automatic logic [63:0] init_of(int d);
    case (d)
      2:       return 64'h0000_0000_FFFF_FFF0;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h0;
    endcase
  endfunction

  function automatic longint unsigned div_of(int d);
    return (d == 1) ? 64'd4 : 64'd1;
  endfunction

  // mtime seen at the k-th edge after reset, before that edge's increment.
  function automatic logic [63:0] mt(int d, longint unsigned k);
    return init_of(d) + 64'(k / div_of(d));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  longint unsigned k;
  logic        pend  [4];
  logic [1:0]  eresp [4];
  logic [31:0] edata [4];
  logic [31:0] snap  [4];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      k <= 0;
      for (int d = 0; d < 4; d++) begin
        pend[d]  <= 1'b0;
        eresp[d] <= 2'b00;
        edata[d] <= 32'h0;
        snap[d]  <= 32'h0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (!pend[d]) begin
          if (arvalid) begin
            pend[d] <= 1'b1;
            if (araddr[31:3] == 29'(32'h2000_bff8 >> 3)) begin
              eresp[d] <= 2'b00;
              if (high) begin
`ifdef CLINT_SNAPSHOT_EN
                edata[d] <= snap[d];
`else
                edata[d] <= mt(d, k) >> 32;
`endif
              end else begin
                edata[d] <= 32'(mt(d, k));
                snap[d]  <= mt(d, k) >> 32;
              end
            end else begin
              eresp[d] <= 2'b11;
              edata[d] <= 32'h0;
            end
          end
        end else if (rready) begin
          pend[d] <= 1'b0;
        end
      end
      k <= k + 1;
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 4; d++) begin
      check($sformatf("hs%0d", d),
            {30'h0, o_arready[d], o_rvalid[d]},
            {30'h0, !pend[d], pend[d]});
      if (pend[d]) begin
        check($sformatf("rresp%0d", d), {30'h0, o_rresp[d]}, {30'h0, eresp[d]});
        check($sformatf("rdata%0d", d), o_rdata[d], edata[d]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic rd(input logic [31:0] a, input logic h);
    araddr  = a;
    high    = h;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
  endtask

  task automatic ack();
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_arready", {31'h0, if0.arready}, 32'h1);
    check("rst_rvalid", {31'h0, if0.rvalid}, 32'h0);
    check("rst_rresp", {30'h0, if0.rresp}, 32'h0);
    check("rst_rdata", if0.rdata, 32'h0);
    reset = 1'b0;

    repeat (5) step();
    check("pre_rvalid", {31'h0, if0.rvalid}, 32'h0);
    rd(32'h2000_bff8, 1'b0);
    #1;
    check("lat_rvalid", {31'h0, if0.rvalid}, 32'h1);
    check("lo_at5", if0.rdata, 32'h5);
    check("lo_at5_div4", if1.rdata, 32'h1);
    check("lo_at5_okay", {30'h0, if0.rresp}, 32'h0);

    repeat (10) begin
      step();
      check("bp_rdata", if0.rdata, 32'h5);
      check("bp_arready", {31'h0, if0.arready}, 32'h0);
    end
    ack();
    #1;
    check("rel_rvalid", {31'h0, if0.rvalid}, 32'h0);
    check("rel_arready", {31'h0, if0.arready}, 32'h1);

    step();
    rd(32'h2000_bff0, 1'b0);
    #1;
    check("decerr_resp", {30'h0, if0.rresp}, 32'h3);
    check("decerr_data", if0.rdata, 32'h0);
    ack();

    rd(32'h2000_bffc, 1'b0);
    ack();
    rd(32'h2000_bffc, 1'b1);
    ack();

    rd(32'h2000_bff8, 1'b0);
    step();
    #1;
    reset = 1'b1;
    #1;
    check("mid_arready", {31'h0, if0.arready}, 32'h1);
    check("mid_rvalid", {31'h0, if0.rvalid}, 32'h0);
    check("mid_rresp", {30'h0, if2.rresp}, 32'h0);
    check("mid_rdata", if2.rdata, 32'h0);
    step();
    reset = 1'b0;

    repeat (40) step();
    rd(32'h2000_bff8, 1'b0);
    #1;
    check("div4_at40", if1.rdata, 32'd10);
    ack();

    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (14) step();
    rd(32'h2000_bff8, 1'b0);
    #1;
    check("snap_lo", if2.rdata, 32'hFFFF_FFFE);
    ack();
    rd(32'h2000_bffc, 1'b1);
    #1;
`ifdef CLINT_SNAPSHOT_EN
    check("snap_hi", if2.rdata, 32'h0);
`else
    check("live_hi", if2.rdata, 32'h1);
`endif
    ack();

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rd(32'h2000_bff8, 1'b0);
    #1;
    check("wrap_lo", if3.rdata, 32'h0);
    ack();
    rd(32'h2000_bffc, 1'b1);
    #1;
    check("wrap_hi", if3.rdata, 32'h0);
    ack();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_clint.md
# ysyx_20020207_clint

AXI4-Lite read-only responder for the core-local timer (CLINT mtime). It sits behind the crossbar's port 2, which routes reads of 0x2000_bff8 and 0x2000_bffc here and flags the upper word on `high`. It keeps a free-running 64-bit tick counter and returns one 32-bit half per AR/R transaction, registered, with full valid/ready backpressure.

## Interface
- `TICK_DIV`, default 1: core clocks per mtime increment; must be ≥1.
- `MTIME_INIT`, default 64'h0: mtime value loaded on reset; used for test and bring-up.
- `ADDR_LO`, default 32'h2000_bff8: address of the low word; the high word is at `ADDR_LO`+4.
- `clock` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `arvalid` input 1: read-address valid.
- `araddr` input 32: read address.
- `high` input 1: crossbar word select; 1 = upper 32 bits.
- `arready` output 1: address accept.
- `rvalid` output 1: read data valid.
- `rresp` output 2: response code; 2'b00 OKAY, 2'b11 DECERR.
- `rdata` output 32: read data.
- `rready` input 1: read data accept.

## Operation
- **mtime:** 64-bit register.
  - Prescaler counter `div` counts 0..`TICK_DIV`-1.
  - When `div` == `TICK_DIV`-1: `div` returns to 0 and mtime increments by 1.
  - Modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - Carry from bit 31 into bit 32 happens in the same cycle.
  - When `TICK_DIV`=1, mtime increments every cycle.
  - Counting continues regardless of bus activity.
- **FSM states:** IDLE and RESP.
  - IDLE: `arready`=1, `rvalid`=0.
  - On `arvalid` && `arready`, capture the response and go to RESP.
  - RESP: `arready`=0, `rvalid`=1. `rdata` and `rresp` are held stable.
  - RESP with `rready`=1: go to IDLE at the next edge.
  - RESP with `rready`=0: stay in RESP indefinitely.
- **Decode at AR handshake:**
  - OKAY when `araddr[31:3]` == `ADDR_LO[31:3]`.
  - Otherwise the response is DECERR with `rdata`=0, and no state changes except the FSM.
- **Data selected at AR handshake:**
  - `high`=0: `rdata`=mtime[31:0].
  - `high`=1: `rdata`=mtime[63:32], or the snapshot (see Configuration).
  - The value is mtime as it stands in the handshake cycle, before that edge's increment.
- `araddr[2]` is ignored; `high` alone selects the word.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and any pending response is dropped.

## Timing
- Reset values:
  - `arready`=1, `rvalid`=0, `rresp`=2'b00, `rdata`=0.
  - mtime=`MTIME_INIT`, `div`=0, snapshot=0.
- Latency: `rvalid` rises one cycle after the AR handshake edge.
- Minimum transaction period is 2 cycles. `arready` is low throughout RESP, so a new AR cannot be accepted in the same cycle as an R handshake.
- Outputs are driven from registers or from the FSM state only; there is no combinational path from inputs to outputs.
- `arvalid` asserted during RESP is held off by the initiator until IDLE.

## Configuration
- Macro: `CLINT_SNAPSHOT_EN`.
- **Defined:** a successful low-word read latches mtime[63:32] into a 32-bit snapshot register in the handshake cycle. A subsequent high-word read returns the snapshot, which gives a carry-coherent 64-bit read (low then high). DECERR reads do not update the snapshot.
- **Undefined:** there is no snapshot register, and high-word reads return live mtime[63:32].

## Test plan
- **Reset values:** assert `reset` mid-cycle → outputs go to reset values asynchronously. Deassert, then read the low word when mtime=5 (`TICK_DIV`=1) → `rdata`=32'h5, `rresp`=00, `rvalid` one cycle after the handshake.
- **Backpressure:** hold `rready`=0 for 10 cycles after `rvalid` → `rdata` unchanged and `arready`=0 throughout. Raise `rready` → `rvalid`=0 and `arready`=1 the next cycle.
- **Prescaler:** with `TICK_DIV`=4, after 40 cycles with no bus activity, read the low word → `rdata`=10.
- **Decode error:** AR with `araddr`=32'h2000_bff0 → `rresp`=2'b11, `rdata`=0.
- **Snapshot vs. live:** `MTIME_INIT`=64'h0000_0000_FFFF_FFF0, `TICK_DIV`=1.
  - Low-word read handshake at mtime 0xFFFF_FFFE → `rdata`=0xFFFF_FFFE.
  - High-word read after the carry → `rdata`=0 with `CLINT_SNAPSHOT_EN`, `rdata`=1 without it.
- **Wrap:** `MTIME_INIT`=64'hFFFF_FFFF_FFFF_FFFF, `TICK_DIV`=1. Reading low then high after the first increment → 0 and 0.
